// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the address-region type used by the memory stage.
package riscv_pkg;
  localparam int          XLEN              = 32;
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;
  localparam logic [31:0] GPIO_OFS          = 32'h0000_0000;
  localparam logic [31:0] CYCLE_OFS         = 32'h0000_0004;

  typedef enum logic [1:0] {
    RGN_NONE  = 2'd0,
    RGN_RAM   = 2'd1,
    RGN_GPIO  = 2'd2,
    RGN_CYCLE = 2'd3
  } region_e;
endpackage

// File: rtl/data_memory.sv
// Word-addressed data RAM: asynchronous read, synchronous write, no reset.
module data_memory #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/memory_cycle.sv
// RV32 memory stage: RAM/MMIO decode, GPIO and cycle registers, misalignment
// capture, and the MEM/WB pipeline register.
module memory_cycle
  import riscv_pkg::*;
#(
  parameter int          DMEM_DEPTH = 256,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteM,
  input  logic            MemWriteM,
  input  logic            ResultSrcM,
  input  logic [4:0]      RD_M,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] ALU_ResultM,
  output logic            RegWriteW,
  output logic            ResultSrcW,
  output logic [4:0]      RD_W,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [XLEN-1:0] ALU_ResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] gpio_out,
  output logic            misaligned_err,
  output logic [XLEN-1:0] misaligned_addr
);
  localparam int            AW        = $clog2(DMEM_DEPTH);
  localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(DMEM_DEPTH * 4);

  logic            mem_acc, misal, ram_we;
  region_e         rgn;
  logic [XLEN-1:0] ram_rdata, rdata_d;

  logic            regwrite_q, resultsrc_q, err_q, err_d;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] pc4_q, alu_q, rdata_q, gpio_q, gpio_d, cycle_q, errad_q, errad_d;

  assign mem_acc = MemWriteM | ResultSrcM;
  assign misal   = mem_acc & (ALU_ResultM[1:0] != 2'b00);

  always_comb begin
    rgn = RGN_NONE;
    if (ALU_ResultM < RAM_BYTES)                   rgn = RGN_RAM;
    else if (ALU_ResultM == MMIO_BASE + GPIO_OFS)  rgn = RGN_GPIO;
    else if (ALU_ResultM == MMIO_BASE + CYCLE_OFS) rgn = RGN_CYCLE;
  end

  // Reset wins over a store issued in the same cycle.
  assign ram_we = MemWriteM & ~misal & ~rst & (rgn == RGN_RAM);

  data_memory #(.DEPTH(DMEM_DEPTH), .WIDTH(XLEN)) u_dmem (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ALU_ResultM[AW+1:2]),
    .wdata_i (WriteDataM),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    rdata_d = '0;
    gpio_d  = gpio_q;
    err_d   = err_q;
    errad_d = errad_q;
    if (ResultSrcM && !misal) begin
      unique case (rgn)
        RGN_RAM:   rdata_d = ram_rdata;
        RGN_GPIO:  rdata_d = gpio_q;
        RGN_CYCLE: rdata_d = cycle_q;
        default:   rdata_d = '0;
      endcase
    end
    if (MemWriteM && !misal && rgn == RGN_GPIO) gpio_d = WriteDataM;
    // Only the first misaligned access is recorded.
    if (misal && !err_q) begin
      err_d   = 1'b1;
      errad_d = ALU_ResultM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q  <= 1'b0;
      resultsrc_q <= 1'b0;
      rd_q        <= '0;
      pc4_q       <= '0;
      alu_q       <= '0;
      rdata_q     <= '0;
      gpio_q      <= '0;
      cycle_q     <= '0;
      err_q       <= 1'b0;
      errad_q     <= '0;
    end else begin
      regwrite_q  <= RegWriteM;
      resultsrc_q <= ResultSrcM;
      rd_q        <= RD_M;
      pc4_q       <= PCPlus4M;
      alu_q       <= ALU_ResultM;
      rdata_q     <= rdata_d;
      gpio_q      <= gpio_d;
      cycle_q     <= cycle_q + 1'b1;
      err_q       <= err_d;
      errad_q     <= errad_d;
    end
  end

  assign RegWriteW       = regwrite_q;
  assign ResultSrcW      = resultsrc_q;
  assign RD_W            = rd_q;
  assign PCPlus4W        = pc4_q;
  assign ALU_ResultW     = alu_q;
  assign ReadDataW       = rdata_q;
  assign gpio_out        = gpio_q;
  assign misaligned_err  = err_q;
  assign misaligned_addr = errad_q;
endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle with a word-level reference model.
module tb_memory_cycle;
  localparam int          DEPTH = 256;
  localparam logic [31:0] MMIO  = 32'hFFFF_0000;

  logic        clk = 0, rst = 1;
  logic        RegWriteM = 0, MemWriteM = 0, ResultSrcM = 0;
  logic [4:0]  RD_M = 0;
  logic [31:0] PCPlus4M = 0, WriteDataM = 0, ALU_ResultM = 0;
  logic        RegWriteW, ResultSrcW, misaligned_err;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW, gpio_out, misaligned_addr;

  int checks = 0, errors = 0;

  // Reference model state
  logic [31:0] mem_m [int];
  logic [31:0] gpio_m, cyc_m, eaddr_m, exp_rd;
  logic        err_m;

  memory_cycle #(.DMEM_DEPTH(DEPTH), .MMIO_BASE(MMIO)) dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .RD_W(RD_W), .PCPlus4W(PCPlus4W),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .gpio_out(gpio_out),
    .misaligned_err(misaligned_err), .misaligned_addr(misaligned_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic rs);
    if (!rs || a[1:0] != 2'b00) return 32'h0;
    if (a < DEPTH * 4) return mem_m.exists(int'(a >> 2)) ? mem_m[int'(a >> 2)] : 32'hx;
    if (a == MMIO) return gpio_m;
    if (a == MMIO + 4) return cyc_m;
    return 32'h0;
  endfunction

  // One pipeline cycle: drive M inputs, predict, clock, advance model.
  task automatic op(input logic r, input logic rw, input logic mw, input logic rs,
                    input logic [4:0] rd, input logic [31:0] a, input logic [31:0] wd);
    rst = r; RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
    ALU_ResultM = a; WriteDataM = wd; PCPlus4M = $urandom;
    exp_rd = r ? 32'h0 : model_read(a, rs);
    @(posedge clk);
    if (r) begin
      gpio_m = 0; cyc_m = 0; err_m = 0; eaddr_m = 0;
    end else begin
      if ((mw || rs) && a[1:0] != 2'b00) begin
        if (!err_m) begin err_m = 1; eaddr_m = a; end
      end else if (mw) begin
        if (a < DEPTH * 4) mem_m[int'(a >> 2)] = wd;
        else if (a == MMIO) gpio_m = wd;
      end
      cyc_m = cyc_m + 1;
    end
    #1;
  endtask

  task automatic load(input logic [4:0] rd, input logic [31:0] a);
    op(0, 1, 0, 1, rd, a, 32'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    op(0, 0, 1, 0, 5'd0, a, d);
  endtask

  task automatic test_reset;
    op(1, 1, 1, 1, 5'd7, 32'h10, 32'h1234_5678);
    op(1, 1, 1, 1, 5'd7, MMIO, 32'h1234_5678);
    checks++;
    if ({RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, gpio_out,
         misaligned_err, misaligned_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%0d pc=%h alu=%h rdata=%h gpio=%h err=%b ea=%h, need all 0",
               RD_W, PCPlus4W, ALU_ResultW, ReadDataW, gpio_out, misaligned_err, misaligned_addr);
    end
    repeat (3) op(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    load(5'd1, MMIO + 4);
    checks++;
    if (ReadDataW !== 32'd3) begin
      errors++; $display("FAIL reset_cycle3: got %h need %h", ReadDataW, 32'd3);
    end
  endtask

  task automatic test_store_load;
    store(32'h10, 32'hDEAD_BEEF);
    load(5'd5, 32'h10);
    checks++;
    if (ReadDataW !== 32'hDEAD_BEEF || RD_W !== 5'd5 || RegWriteW !== 1'b1 || ResultSrcW !== 1'b1) begin
      errors++;
      $display("FAIL store_load: got rdata=%h rd=%0d rw=%b rs=%b need DEADBEEF 5 1 1",
               ReadDataW, RD_W, RegWriteW, ResultSrcW);
    end
  endtask

  task automatic test_mmio;
    store(MMIO, 32'h0000_00A5);
    checks++;
    if (gpio_out !== 32'hA5) begin
      errors++; $display("FAIL gpio_write: got %h need %h", gpio_out, 32'hA5);
    end
    store(MMIO + 4, 32'h0);
    load(5'd2, MMIO + 4);
    checks++;
    if (ReadDataW !== exp_rd) begin
      errors++; $display("FAIL cycle_ro: got %h need %h", ReadDataW, exp_rd);
    end
    load(5'd3, MMIO);
    checks++;
    if (ReadDataW !== 32'hA5) begin
      errors++; $display("FAIL gpio_read: got %h need %h", ReadDataW, 32'hA5);
    end
  endtask

  task automatic test_misaligned;
    store(32'h13, 32'h1111_2222);
    checks++;
    if (misaligned_err !== 1'b1 || misaligned_addr !== 32'h13) begin
      errors++; $display("FAIL misal_first: got err=%b addr=%h need 1 13", misaligned_err, misaligned_addr);
    end
    load(5'd4, 32'h10);
    checks++;
    if (ReadDataW !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL misal_no_store: got %h need DEADBEEF", ReadDataW);
    end
    load(5'd4, 32'h22);
    checks++;
    if (ReadDataW !== 32'h0 || misaligned_addr !== 32'h13 || misaligned_err !== 1'b1) begin
      errors++; $display("FAIL misal_sticky: got rdata=%h addr=%h err=%b need 0 13 1",
                         ReadDataW, misaligned_addr, misaligned_err);
    end
  endtask

  task automatic test_unmapped;
    load(5'd6, 32'h8000_0000);
    checks++;
    if (ReadDataW !== 32'h0 || misaligned_err !== err_m || misaligned_addr !== eaddr_m) begin
      errors++; $display("FAIL unmapped_load: got rdata=%h err=%b addr=%h need 0 %b %h",
                         ReadDataW, misaligned_err, misaligned_addr, err_m, eaddr_m);
    end
    op(0, 1, 0, 0, 5'd9, 32'h0000_0011, 32'hFFFF_FFFF);
    checks++;
    if (ALU_ResultW !== 32'h11 || ReadDataW !== 32'h0 || PCPlus4W !== PCPlus4M || RD_W !== 5'd9) begin
      errors++; $display("FAIL alu_pass: got alu=%h rdata=%h pc=%h rd=%0d need 11 0 %h 9",
                         ALU_ResultW, ReadDataW, PCPlus4W, RD_W, PCPlus4M);
    end
  endtask

  task automatic test_reset_store;
    op(1, 0, 1, 0, 5'd0, 32'h10, 32'h0BAD_0BAD);
    checks++;
    if (misaligned_err !== 1'b0 || gpio_out !== 32'h0) begin
      errors++; $display("FAIL reset_clear: got err=%b gpio=%h need 0 0", misaligned_err, gpio_out);
    end
    load(5'd5, 32'h10);
    checks++;
    if (ReadDataW !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL reset_store: got %h need DEADBEEF", ReadDataW);
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int w = 0; w < 16; w++) store(32'(w * 4), $urandom);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    a = 32'($urandom_range(0, 15) * 4);
        2:       a = MMIO;
        3:       a = MMIO + 4;
        4:       a = 32'($urandom_range(0, 63));
        default: a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4);
      endcase
      op(0, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), a, $urandom);
      checks++;
      if (ReadDataW !== exp_rd || gpio_out !== gpio_m || misaligned_err !== err_m ||
          misaligned_addr !== eaddr_m || ALU_ResultW !== a || PCPlus4W !== PCPlus4M ||
          RD_W !== RD_M || RegWriteW !== RegWriteM || ResultSrcW !== ResultSrcM) begin
        errors++;
        $display("FAIL random[%0d] a=%h: got rdata=%h gpio=%h err=%b ea=%h need %h %h %b %h",
                 i, a, ReadDataW, gpio_out, misaligned_err, misaligned_addr,
                 exp_rd, gpio_m, err_m, eaddr_m);
      end
    end
  endtask

  task automatic test_wrap;
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1 release dut.cycle_q;
    cyc_m = 32'hFFFF_FFFF;
    load(5'd1, MMIO + 4);
    checks++;
    if (ReadDataW !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_max: got %h need FFFFFFFF", ReadDataW);
    end
    load(5'd1, MMIO + 4);
    checks++;
    if (ReadDataW !== 32'h0) begin
      errors++; $display("FAIL wrap_zero: got %h need 0", ReadDataW);
    end
  endtask

  initial begin
    gpio_m = 0; cyc_m = 0; err_m = 0; eaddr_m = 0; exp_rd = 0;
    @(negedge clk);
    test_reset;
    test_store_load;
    test_mmio;
    test_misaligned;
    test_unmapped;
    test_reset_store;
    test_random;
    test_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory stage of the 5-stage RV32 pipeline: consumes the execute-stage outputs (M-stage signals), performs word loads/stores against an internal data memory and a small memory-mapped I/O window, and registers results into the MEM/WB pipeline register for the writeback stage. It also flags misaligned accesses and provides a free-running cycle counter readable by software.

## Interface
- DMEM_DEPTH, 256: data memory size in 32-bit words (power of two, ≥4).
- MMIO_BASE, 32'hFFFF_0000: base byte address of the I/O window.

- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- RegWriteM  input  1  register-file write enable of the M-stage instruction.
- MemWriteM  input  1  store enable.
- ResultSrcM  input  1  1 = load (writeback selects read data), 0 = ALU/other.
- RD_M  input  5  destination register.
- PCPlus4M  input  32  PC+4 of the M-stage instruction.
- WriteDataM  input  32  store data (already forwarded upstream).
- ALU_ResultM  input  32  effective byte address / ALU result.
- RegWriteW  output  1  registered RegWriteM.
- ResultSrcW  output  1  registered ResultSrcM.
- RD_W  output  5  registered RD_M.
- PCPlus4W  output  32  registered PCPlus4M.
- ALU_ResultW  output  32  registered ALU_ResultM.
- ReadDataW  output  32  registered load data.
- gpio_out  output  32  software-writable output register.
- misaligned_err  output  1  sticky: a misaligned load/store was seen.
- misaligned_addr  output  32  address of the first misaligned access.

## Operation
- Address decode on ALU_ResultM (only when MemWriteM=1 or ResultSrcM=1):
  - RAM: ALU_ResultM < DMEM_DEPTH*4; word index = ALU_ResultM[$clog2(DMEM_DEPTH)+1:2].
  - GPIO: MMIO_BASE+0, read/write.
  - CYCLE: MMIO_BASE+4, read-only; writes ignored.
  - Any other address: reads return 0, writes ignored, no error.
- Misaligned: ALU_ResultM[1:0] != 0 with MemWriteM or ResultSrcM. Store suppressed; load returns 0. On first occurrence misaligned_err←1 and misaligned_addr←ALU_ResultM; later ones do not overwrite. Cleared only by rst.
- RAM read is combinational (asynchronous) in M; write is synchronous at the edge ending the M cycle.
- Cycle counter: 32-bit, 0 in reset, +1 every non-reset edge, wraps 32'hFFFF_FFFF→0.
- Read data mux: RAM word, gpio_out, or counter current value; ReadDataW captures it at the edge ending M. ReadDataW captures 0 when instruction is not a load.
- All other M-stage fields pass to W unchanged.

## Timing
- Latency M→W: 1 cycle for every field.
- Store at cycle n visible to a load of the same address at cycle n+1 (no bypass needed within M).
- Load of CYCLE in M cycle n (n edges after reset release) returns n.
- gpio_out updates at the edge ending the store's M cycle.
- Reset: all outputs 0, counter 0, error flag/addr 0; RAM contents not reset (undefined until written). rst asserted in the same cycle as a store: store suppressed, rst wins.
- No stall/flush inputs; one instruction per cycle.

## Structure
- Shared package riscv_pkg: MMIO_BASE default, offsets GPIO_OFS=0, CYCLE_OFS=4, XLEN=32.
- Sub-module data_memory: DMEM_DEPTH×32 array, async read, sync write with write enable; no reset.
- Decode, MMIO registers, counter, error capture and MEM/WB register live in memory_cycle.

## Test plan
- Reset: hold rst 2 cycles → all outputs 0; release, load CYCLE 3 edges later → ReadDataW=3 next cycle.
- Store 32'hDEAD_BEEF to 0x10, then load 0x10 next cycle with RD_M=5, RegWriteM=1 → ReadDataW=DEADBEEF, RD_W=5, RegWriteW=1.
- Store 32'h0000_00A5 to MMIO_BASE → gpio_out=A5 after edge; store to MMIO_BASE+4 → counter unaffected.
- Store to 0x13 → RAM unchanged (load 0x10 returns old value), misaligned_err=1, misaligned_addr=0x13; later load 0x22 leaves addr 0x13.
- Load from 0x8000_0000 → ReadDataW=0, misaligned_err unchanged; non-load ALU op → ALU_ResultW=input, ReadDataW=0.
- Store with rst=1 same cycle → location unchanged; counter wrap forced near 32'hFFFF_FFFF → reads 0 after wrap.
